// File: rtl/i2c_target_regs.sv
// ---------------------------------------------------------------------------
// i2c_target_regs
//
// I2C target endpoint with a 4-byte register bank. It decodes START and STOP,
// matches a 7-bit device address and acknowledges it. Master writes go into
// the bank through an auto-incrementing 2-bit pointer. Master reads are
// served from the bank. A local combinational read port exposes the bank to
// on-chip logic.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   scl_in     bus SCL (asynchronous, synchronized internally)
//   sda_in     bus SDA (asynchronous, synchronized internally)
//   sda_oe     1 = pull SDA low, 0 = release (registered)
//   reg_sel    local read index
//   reg_q      bank[reg_sel] (combinational)
//   wr_strobe  one-cycle pulse when a received byte is committed
//   wr_idx     bank index being written on the wr_strobe cycle
//   busy       high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h2A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [1:0] reg_sel,
  output logic [7:0] reg_q,
  output logic       wr_strobe,
  output logic [1:0] wr_idx,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WRITE, ST_WR_ACK, ST_READ, ST_RD_ACK, ST_WAIT
  } state_t;

  // Synchronizers plus one delayed copy for edge detection. The flops reset
  // to 1 (the idle bus level) so that leaving reset never creates a false
  // START.
  logic scl_meta_reg, scl_sync_reg, scl_prev_reg;
  logic sda_meta_reg, sda_sync_reg, sda_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta_reg <= 1'b1;
      scl_sync_reg <= 1'b1;
      scl_prev_reg <= 1'b1;
      sda_meta_reg <= 1'b1;
      sda_sync_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_meta_reg <= scl_in;
      scl_sync_reg <= scl_meta_reg;
      scl_prev_reg <= scl_sync_reg;
      sda_meta_reg <= sda_in;
      sda_sync_reg <= sda_meta_reg;
      sda_prev_reg <= sda_sync_reg;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_sync_reg & ~scl_prev_reg;
  assign scl_fall  = ~scl_sync_reg & scl_prev_reg;
  assign start_det = scl_sync_reg & sda_prev_reg & ~sda_sync_reg;
  assign stop_det  = scl_sync_reg & ~sda_prev_reg & sda_sync_reg;

  state_t      state_reg, state_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic [1:0]  ptr_reg, ptr_next;
  logic        sda_oe_reg, sda_oe_next;
  // Within an ACK slot: 0 = waiting for the fall that starts driving ACK,
  // 1 = waiting for the fall that ends the ACK clock.
  logic        ack_phase_reg, ack_phase_next;
  logic        wr_strobe_reg, wr_strobe_next;
  logic [1:0]  wr_idx_reg, wr_idx_next;
  logic [7:0]  wr_data_reg, wr_data_next;
  logic [7:0]  bank_reg [4];

  logic [1:0]  ptr_inc;
  logic [7:0]  rx_byte;
  assign ptr_inc = ptr_reg + 2'd1;
  assign rx_byte = {shift_reg[6:0], sda_sync_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= 4'd0;
      shift_reg     <= 8'h00;
      ptr_reg       <= 2'd0;
      sda_oe_reg    <= 1'b0;
      ack_phase_reg <= 1'b0;
      wr_strobe_reg <= 1'b0;
      wr_idx_reg    <= 2'd0;
      wr_data_reg   <= 8'h00;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      ptr_reg       <= ptr_next;
      sda_oe_reg    <= sda_oe_next;
      ack_phase_reg <= ack_phase_next;
      wr_strobe_reg <= wr_strobe_next;
      wr_idx_reg    <= wr_idx_next;
      wr_data_reg   <= wr_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    ptr_next       = ptr_reg;
    sda_oe_next    = sda_oe_reg;
    ack_phase_next = ack_phase_reg;
    wr_strobe_next = 1'b0;
    wr_idx_next    = wr_idx_reg;
    wr_data_next   = wr_data_reg;

    // START/STOP win over any coincident SCL edge; a partial byte is simply
    // abandoned because the bank is only written on the 8th rise.
    if (start_det) begin
      bit_cnt_next   = 4'd0;
      ptr_next       = 2'd0;
      sda_oe_next    = 1'b0;
      ack_phase_next = 1'b0;
      state_next     = ST_ADDR;
    end else if (stop_det) begin
      sda_oe_next = 1'b0;
      state_next  = ST_IDLE;
    end else begin
      case (state_reg)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) begin
              ack_phase_next = 1'b0;
              // Address bits are the first seven received, i.e. shift_reg[6:0].
              state_next = (shift_reg[6:0] == DEV_ADDR) ? ST_ADDR_ACK : ST_IDLE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_reg) begin
              sda_oe_next    = 1'b1;
              ack_phase_next = 1'b1;
            end else begin
              ack_phase_next = 1'b0;
              bit_cnt_next   = 4'd0;
              if (!shift_reg[0]) begin
                sda_oe_next = 1'b0;
                state_next  = ST_WRITE;
              end else begin
                shift_next  = bank_reg[ptr_reg];
                sda_oe_next = ~bank_reg[ptr_reg][7];
                state_next  = ST_READ;
              end
            end
          end
        end
        ST_WRITE: begin
          if (scl_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) begin
              wr_strobe_next = 1'b1;
              wr_idx_next    = ptr_reg;
              wr_data_next   = rx_byte;
              ptr_next       = ptr_inc;
              ack_phase_next = 1'b0;
              state_next     = ST_WR_ACK;
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_reg) begin
              sda_oe_next    = 1'b1;
              ack_phase_next = 1'b1;
            end else begin
              sda_oe_next    = 1'b0;
              ack_phase_next = 1'b0;
              bit_cnt_next   = 4'd0;
              state_next     = ST_WRITE;
            end
          end
        end
        ST_READ: begin
          // bit_cnt counts rises already clocked out; on each fall present
          // the next bit, or release once all eight have been clocked.
          if (scl_rise && bit_cnt_reg != 4'd8) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              sda_oe_next = 1'b0;
              state_next  = ST_RD_ACK;
            end else begin
              sda_oe_next = ~shift_reg[3'd7 - bit_cnt_reg[2:0]];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_sync_reg) begin
              ptr_next     = ptr_inc;
              shift_next   = bank_reg[ptr_inc];
              bit_cnt_next = 4'd0;
              state_next   = ST_READ;
            end else begin
              state_next = ST_WAIT;
            end
          end
        end
        default: ;  // IDLE and WAIT only react to START/STOP
      endcase
    end
  end

  // Bank bytes commit the cycle after wr_strobe.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bank_reg[gi] <= 8'h00;
        end else if (wr_strobe_reg && wr_idx_reg == 2'(gi)) begin
          bank_reg[gi] <= wr_data_reg;
        end
      end
    end
  endgenerate

  assign sda_oe    = sda_oe_reg;
  assign wr_strobe = wr_strobe_reg;
  assign wr_idx    = wr_idx_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign reg_q     = bank_reg[reg_sel];

endmodule

// File: tb/tb_i2c_target_regs.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regs
//
// Bit-level I2C master driving i2c_target_regs over an open-drain bus model.
// Expected results come from a simple transaction-level model: a 4-byte
// array plus a pointer that is cleared by START and advanced per byte.
// ---------------------------------------------------------------------------
module tb_i2c_target_regs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic [1:0] reg_sel;
  logic [7:0] reg_q;
  logic       wr_strobe;
  logic [1:0] wr_idx;
  logic       busy;

  always #5 clk = ~clk;

  // Open-drain wired-AND of master and target.
  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_regs #(.DEV_ADDR(7'h2A)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .reg_sel   (reg_sel),
    .reg_q     (reg_q),
    .wr_strobe (wr_strobe),
    .wr_idx    (wr_idx),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model.
  logic [7:0] bank_m [4];
  logic [1:0] ptr_m;
  logic [1:0] exp_q [$];
  logic [1:0] strobe_q [$];
  logic [7:0] wdata [8];
  int         oe_cnt;

  always @(negedge clk) begin
    if (wr_strobe) strobe_q.push_back(wr_idx);
    if (sda_oe) oe_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL clock starting and ending with SCL low; rx is the bus value
  // sampled in the middle of the high phase.
  task automatic clock_bit(input logic b, output logic rx);
    tick(4);
    sda_m = b;
    tick(6);
    scl = 1'b1;
    tick(5);
    rx = sda_bus;
    tick(5);
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic rx;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], rx);
    clock_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic rx;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, rx);
      d[i] = rx;
    end
    clock_bit(nack, rx);
  endtask

  task automatic bus_start();
    tick(4);
    sda_m = 1'b1;
    tick(6);
    scl = 1'b1;
    tick(6);
    sda_m = 1'b0;
    tick(6);
    scl = 1'b0;
    ptr_m = 2'd0;
  endtask

  task automatic bus_stop();
    tick(4);
    sda_m = 1'b0;
    tick(6);
    scl = 1'b1;
    tick(6);
    sda_m = 1'b1;
    tick(6);
  endtask

  task automatic check_strobes();
    check("strobe_count", strobe_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < strobe_q.size(); i++)
      check("strobe_idx", strobe_q[i], exp_q[i]);
    strobe_q.delete();
    exp_q.delete();
  endtask

  task automatic check_bank();
    for (int s = 0; s < 4; s++) begin
      reg_sel = 2'(s);
      tick(1);
      check($sformatf("bank%0d", s), reg_q, bank_m[s]);
    end
  endtask

  task automatic write_xfer(input logic [6:0] addr, input int n);
    logic ack;
    logic match;
    match = (addr == 7'h2A);
    bus_start();
    send_byte({addr, 1'b0}, ack);
    check("addr_ack", ack, match ? 0 : 1);
    if (!match) check("busy_after_nomatch", busy, 0);
    for (int i = 0; i < n; i++) begin
      send_byte(wdata[i], ack);
      check("data_ack", ack, match ? 0 : 1);
      if (match) begin
        bank_m[ptr_m] = wdata[i];
        exp_q.push_back(ptr_m);
        ptr_m = ptr_m + 2'd1;
      end
    end
    bus_stop();
    check("busy_after_stop", busy, 0);
    check("oe_after_stop", sda_oe, 0);
    check_strobes();
    check_bank();
  endtask

  task automatic read_xfer(input int n);
    logic       ack;
    logic       rx;
    logic [7:0] d;
    bus_start();
    send_byte({7'h2A, 1'b1}, ack);
    check("rd_addr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, d);
      check("rd_data", d, bank_m[ptr_m]);
      if (i != n - 1) ptr_m = ptr_m + 2'd1;
    end
    tick(6);
    check("oe_in_wait", sda_oe, 0);
    check("busy_in_wait", busy, 1);
    clock_bit(1'b1, rx);
    check("wait_released", rx, 1);
    bus_stop();
    check("busy_after_rd_stop", busy, 0);
    check_strobes();
  endtask

  initial begin
    logic ack;
    logic rx;
    logic [6:0] addr;
    int k;
    int n;

    rst_n   = 1'b0;
    scl     = 1'b1;
    sda_m   = 1'b1;
    reg_sel = 2'd0;
    ptr_m   = 2'd0;
    oe_cnt  = 0;
    for (int s = 0; s < 4; s++) bank_m[s] = 8'h00;
    tick(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_idx", wr_idx, 0);
    rst_n = 1'b1;
    tick(3);
    check_bank();

    // Single write of 0x55.
    wdata[0] = 8'h55;
    write_xfer(7'h2A, 1);

    // Single read, master NACK.
    read_xfer(1);

    // Five-byte write wraps the pointer.
    wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33;
    wdata[3] = 8'h44; wdata[4] = 8'h55;
    write_xfer(7'h2A, 5);

    // Three-byte read: ACK, ACK, NACK.
    read_xfer(3);

    // Wrong address: target must never drive SDA.
    oe_cnt   = 0;
    wdata[0] = 8'hAA;
    write_xfer(7'h2B, 1);
    check("nomatch_oe_cycles", oe_cnt, 0);

    // Randomized transfers.
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) wdata[i] = 8'($urandom);
      addr = ($urandom_range(0, 3) == 0) ? (7'h2A ^ 7'($urandom_range(1, 127))) : 7'h2A;
      write_xfer(addr, n);
      read_xfer($urandom_range(1, 5));
    end

    // Repeated START after four data bits drops the partial byte.
    bus_start();
    send_byte(8'h54, ack);
    check("rs_addr_ack1", ack, 0);
    wdata[0] = 8'($urandom);
    send_byte(wdata[0], ack);
    check("rs_data_ack1", ack, 0);
    bank_m[ptr_m] = wdata[0];
    exp_q.push_back(ptr_m);
    ptr_m = ptr_m + 2'd1;
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom), rx);
    bus_start();
    send_byte(8'h54, ack);
    check("rs_addr_ack2", ack, 0);
    wdata[1] = 8'($urandom);
    send_byte(wdata[1], ack);
    check("rs_data_ack2", ack, 0);
    bank_m[ptr_m] = wdata[1];
    exp_q.push_back(ptr_m);
    ptr_m = ptr_m + 2'd1;
    bus_stop();
    check_strobes();
    check_bank();

    // Reset while the target pulls SDA low in READ.
    wdata[0] = 8'h3C;
    write_xfer(7'h2A, 1);
    bus_start();
    send_byte(8'h55, ack);
    check("rst_rd_addr_ack", ack, 0);
    k = 0;
    while (!sda_oe && k < 10) begin
      tick(1);
      k++;
    end
    check("oe_before_reset", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("oe_in_reset", sda_oe, 0);
    check("busy_in_reset", busy, 0);
    for (int s = 0; s < 4; s++) begin
      reg_sel = 2'(s);
      #1;
      check($sformatf("bank%0d_in_reset", s), reg_q, 0);
    end
    tick(2);
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) bank_m[s] = 8'h00;
    ptr_m = 2'd0;
    strobe_q.delete();
    oe_cnt = 0;
    for (int i = 0; i < 9; i++) clock_bit(1'b1, rx);
    check("post_reset_oe_cycles", oe_cnt, 0);
    check("post_reset_busy", busy, 0);
    bus_stop();
    wdata[0] = 8'($urandom);
    wdata[1] = 8'($urandom);
    write_xfer(7'h2A, 2);
    read_xfer(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) endpoint with a 4-byte register bank, answering the I2C master block on the shared two-wire bus. It decodes START/STOP, matches a 7-bit device address and acknowledges it. Master writes are stored into the bank with an auto-incrementing pointer, and master reads are served from it. A local read port exposes the bank to on-chip logic.

## Interface
- `DEV_ADDR`, default 7'h2A: 7-bit address this target answers to.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `scl_in`  in  1  bus SCL, asynchronous to `clk`.
- `sda_in`  in  1  bus SDA, asynchronous to `clk`.
- `sda_oe`  out  1  1 = pull SDA low (open-drain); 0 = release. Registered.
- `reg_sel`  in  2  local read index.
- `reg_q`  out  8  bank[`reg_sel`], combinational.
- `wr_strobe`  out  1  one-cycle pulse when a received byte is committed.
- `wr_idx`  out  2  bank index written on the `wr_strobe` cycle.
- `busy`  out  1  1 while addressed or shifting (state != IDLE).

## Operation
- SCL and SDA each pass through a 2-flop synchronizer. Edge detection uses the synchronized value and its 1-cycle delayed copy.
- START: synced SDA falls while synced SCL is high. Accepted from any state, including as a repeated START. Effects: clear the bit counter, clear the pointer to 0, release SDA, go to ADDR.
- STOP: synced SDA rises while synced SCL is high. Accepted from any state. Effects: release SDA, go to IDLE.
- Data bits are sampled on synced SCL rising edges. SDA is changed only on synced SCL falling edges.
- State machine:
  - IDLE: ignore everything except START.
  - ADDR: shift 8 bits, MSB first; the last bit is R/W. After the 8th rising edge:
    - address == `DEV_ADDR`: go to ADDR_ACK.
    - otherwise: go to IDLE and never drive SDA.
  - ADDR_ACK: at the next SCL fall, set `sda_oe`=1. At the following fall:
    - R/W=0: set `sda_oe`=0, go to WRITE.
    - R/W=1: load shift register from bank[ptr], drive bit 7 (`sda_oe` = ~bit), go to READ.
  - WRITE: shift 8 bits. On the 8th rising edge:
    - bank[ptr] <= byte, pulse `wr_strobe` with `wr_idx`=ptr.
    - ptr <= ptr+1 (mod 4, wraps 3->0).
    - go to WR_ACK.
  - WR_ACK: assert `sda_oe` on the next SCL fall, release it on the following fall, return to WRITE. Every write byte is ACKed.
  - READ: present the next bit on each SCL fall. After the 8th bit's clock, release SDA on the following fall and go to RD_ACK.
  - RD_ACK: sample SDA on the SCL rise.
    - 0 (ACK): ptr <= ptr+1 mod 4, reload shift register from bank[new ptr], drive bit 7 on the next fall, go to READ.
    - 1 (NACK): go to WAIT.
  - WAIT: SDA released; leave only on START or STOP.
- Pointer reset: the pointer clears only on START and on reset.
- Reset (asynchronous, mid-transfer allowed) forces:
  - state = IDLE, `sda_oe`=0, `wr_strobe`=0, `busy`=0;
  - all bank bytes 8'h00, ptr=0, `wr_idx`=0.

## Timing
- Input synchronizer latency: 2 `clk` cycles. Edge detection adds 1 cycle. `sda_oe` changes at most 4 `clk` edges after the SCL pin edge that triggers it.
- Bus constraint: SCL high and low phases ≥ 6 `clk` cycles. SDA setup/hold around SCL edges ≥ 3 `clk` cycles.
- `wr_strobe` is high for exactly 1 cycle, 3–4 cycles after the 8th data SCL rise. The bank update is visible on `reg_q` the cycle after `wr_strobe`.
- START/STOP take priority over a coincident SCL edge in the same cycle.
- A START or STOP arriving mid-byte discards the partial byte; the bank is not written.
- `busy` rises the cycle ADDR is entered and falls the cycle IDLE is entered.

## Test plan
- Write to address 0x2A: START, byte 0x54 (0x2A + W), data 0x55, STOP. Required: `sda_oe`=1 during both ACK clocks; one `wr_strobe` with `wr_idx`=0; `reg_sel`=0 gives `reg_q`=0x55; `busy` returns to 0 after STOP.
- Read: preload bank[0]=0x55, then START, 0x55 (0x2A + R). Required: ACK, then SDA bit stream 0-1-0-1-0-1-0-1. Master NACKs, STOP. Required: `sda_oe`=0 after the 8th bit; no `wr_strobe`.
- Multi-byte write with wrap: data 0x11, 0x22, 0x33, 0x44, 0x55 in one transfer. Required: 5 strobes with `wr_idx` 0,1,2,3,0; final bank = {0x55, 0x22, 0x33, 0x44}.
- Multi-byte read with ACK: read 3 bytes, ACK, ACK, NACK. Required: 0x55, 0x22, 0x33 returned; SDA released in WAIT until STOP.
- Wrong address: START, 0x56 (0x2B + W), data 0xAA. Required: `sda_oe` stays 0 throughout; no `wr_strobe`; bank unchanged; `busy`=0 after the address byte.
- Abort cases:
  - Repeated START after 4 data bits. Required: partial byte dropped, pointer=0, new address phase decoded correctly.
  - `rst_n` low for 2 cycles during a READ while `sda_oe`=1. Required: `sda_oe`=0 and bank=0 immediately; bus is ignored until the next START.
